addr_unit: RTL and testbench
============================

ADDR_UNIT -- requirements
Module: addr_unit

Interface
REQ-001 The parameter list SHALL be: WIDTH, 8, bits per address half (address bus is 2*WIDTH bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 op_valid  input  1  new address operation offered this cycle.
REQ-005 op_ready  output  1  unit accepts op this cycle; op_valid is ignored when low.
REQ-006 op  input  4  low-half operation: [3:2] base select, [1:0] add select.
REQ-007 hop  input  2  high-half source: 00 hold ABH, 01 DB high, 10 AH high, 11 PC high.
REQ-008 cp  input  1  propagate low-half carry into high half.
REQ-009 ci  input  1  carry input added to low half.
REQ-010 PC, DB, AH  input  2*WIDTH each  program counter, data bus hold, address hold.
REQ-011 REG  input  WIDTH  register-file output.
REQ-012 AB  output  2*WIDTH  registered address bus, {ABH, ABL}.
REQ-013 co  output  1  registered low-half carry out of the last accepted op.

Function
REQ-014 The low-half base SHALL be 0, DB low, AH low, or PC low for op[3:2] = 00, 01, 10, 11.
REQ-015 The low-half sum SHALL be WIDTH+1 bits: op[1:0] 00 base+ci; 10 base+ABL+ci; 11 base+REG+ci; 01 holds ABL with carry 0.
REQ-016 On an accepted op (op_valid and op_ready), ABL SHALL load sum[WIDTH-1:0] and co SHALL load sum[WIDTH] on the same edge.
REQ-017 On an accepted op, ABH SHALL load the hop-selected source (or hold for hop=00) without carry.
REQ-018 The state machine SHALL have states IDLE and FIXUP; reset state is IDLE; op_ready = 1 in IDLE, 0 in FIXUP.
REQ-019 IDLE to FIXUP SHALL occur on an accepted op with cp=1 and sum[WIDTH]=1; otherwise it remains IDLE.
REQ-020 In FIXUP, ABH SHALL increment by 1 modulo 2^WIDTH, ABL and co SHALL hold, and the next state SHALL be IDLE.
REQ-021 ABH all-ones plus fixup SHALL wrap to 0 with no further carry or flag.
REQ-022 With no accepted op in IDLE, AB and co SHALL hold.
REQ-023 Address latency SHALL be 1 cycle without page crossing and 2 cycles with page crossing (cp=1, carry).

Reset
REQ-024 When rst_n=0 at a clock edge, AB SHALL become 0, co SHALL become 0, and state SHALL become IDLE, overriding any op or FIXUP in progress.
REQ-025 In the cycle after reset release, op_ready SHALL be 1.

Configuration
REQ-026 With ADDR_UNIT_FAST_CARRY_EN defined, an accepted op with cp=1 SHALL add sum[WIDTH] to the selected high source on the same edge (modulo 2^WIDTH), FIXUP SHALL be unreachable, and op_ready SHALL be constant 1.
REQ-027 Without ADDR_UNIT_FAST_CARRY_EN, REQ-019 and REQ-020 SHALL apply.

Structure
REQ-028 A shared package addr_unit_pkg SHALL hold the op[3:2] base-select encodings, the op[1:0] add-select encodings, the hop encodings, and the state enum.
REQ-029 The low-half adder (base mux plus add mux, combinational, WIDTH+1 result) SHALL be a sub-module addr_low_adder; all registers and the FSM SHALL be in addr_unit.

Verification
REQ-030 Reset: hold rst_n=0 during an op with a FIXUP pending -> AB=0000, co=0, op_ready=1 after release.
REQ-031 No cross: WIDTH=8, AB=0000, op=1111, REG=10, PC=1220, hop=11, cp=1, ci=0 -> next cycle AB=1230, co=0, op_ready=1.
REQ-032 Page cross: DB=12F0, REG=20, op=0111, hop=01, cp=1 -> cycle 1 AB=1210, co=1, op_ready=0; cycle 2 AB=1310, op_ready=1.
REQ-033 Wrap: DB=FFFF, op=0100, ci=1, hop=01, cp=1 -> AB=FF00 then AB=0000, co=1.
REQ-034 Stall: op_valid=1 with a different op during FIXUP -> that op is not accepted, AB low holds, and the op is accepted next cycle.
REQ-035 FAST_CARRY build: same stimulus as REQ-032 -> AB=1310 after 1 cycle, op_ready never 0.

Source files
------------

// File: rtl/addr_unit_pkg.sv
// Shared encodings for the address unit: operand selects, high-half source and FSM states.
package addr_unit_pkg;

    typedef enum logic [1:0] {
        BaseZero = 2'b00,
        BaseDb   = 2'b01,
        BaseAh   = 2'b10,
        BasePc   = 2'b11
    } base_sel_e;

    typedef enum logic [1:0] {
        AddCi   = 2'b00,
        AddHold = 2'b01,
        AddAbl  = 2'b10,
        AddReg  = 2'b11
    } add_sel_e;

    typedef enum logic [1:0] {
        HopHold = 2'b00,
        HopDb   = 2'b01,
        HopAh   = 2'b10,
        HopPc   = 2'b11
    } hop_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StFixup = 1'b1
    } state_e;

endpackage

// File: rtl/addr_low_adder.sv
// Combinational low-half address adder: base mux plus add mux, WIDTH+1 bit result.
module addr_low_adder
    import addr_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic             ci,
    input  logic [WIDTH-1:0] db_lo,
    input  logic [WIDTH-1:0] ah_lo,
    input  logic [WIDTH-1:0] pc_lo,
    input  logic [WIDTH-1:0] abl,
    input  logic [WIDTH-1:0] reg_val,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   ci_ext;

    assign ci_ext = {{WIDTH{1'b0}}, ci};

    always_comb begin
        base = '0;
        unique case (base_sel_e'(op[3:2]))
            BaseZero: base = '0;
            BaseDb:   base = db_lo;
            BaseAh:   base = ah_lo;
            BasePc:   base = pc_lo;
            default:  base = '0;
        endcase
    end

    always_comb begin
        sum = '0;
        unique case (add_sel_e'(op[1:0]))
            AddCi:   sum = {1'b0, base} + ci_ext;
            AddHold: sum = {1'b0, abl};
            AddAbl:  sum = {1'b0, base} + {1'b0, abl} + ci_ext;
            AddReg:  sum = {1'b0, base} + {1'b0, reg_val} + ci_ext;
            default: sum = '0;
        endcase
    end

endmodule

// File: rtl/addr_unit.sv
// Address bus generator with page-crossing fixup cycle.
// Optional ADDR_UNIT_FAST_CARRY_EN folds the high-half carry into the same cycle.
module addr_unit
    import addr_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         op,
    input  logic [1:0]         hop,
    input  logic               cp,
    input  logic               ci,
    input  logic [2*WIDTH-1:0] PC,
    input  logic [2*WIDTH-1:0] DB,
    input  logic [2*WIDTH-1:0] AH,
    input  logic [WIDTH-1:0]   REG,
    output logic [2*WIDTH-1:0] AB,
    output logic               co
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] abl_q, abl_d, abh_q, abh_d;
    logic             co_q, co_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_src;
    logic             accept;

    addr_low_adder #(
        .WIDTH(WIDTH)
    ) u_low_adder (
        .op      (op),
        .ci      (ci),
        .db_lo   (DB[WIDTH-1:0]),
        .ah_lo   (AH[WIDTH-1:0]),
        .pc_lo   (PC[WIDTH-1:0]),
        .abl     (abl_q),
        .reg_val (REG),
        .sum     (sum)
    );

    assign accept = op_valid & op_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
`ifndef ADDR_UNIT_FAST_CARRY_EN
        if (state_q == StIdle && accept && cp && sum[WIDTH]) begin
            state_d = StFixup;
        end
`endif
    end

    always_comb begin
`ifdef ADDR_UNIT_FAST_CARRY_EN
        op_ready = 1'b1;
`else
        op_ready = (state_q == StIdle);
`endif
    end

    always_comb begin
        hi_src = abh_q;
        unique case (hop_e'(hop))
            HopHold: hi_src = abh_q;
            HopDb:   hi_src = DB[2*WIDTH-1:WIDTH];
            HopAh:   hi_src = AH[2*WIDTH-1:WIDTH];
            HopPc:   hi_src = PC[2*WIDTH-1:WIDTH];
            default: hi_src = abh_q;
        endcase
    end

    always_comb begin
        abl_d = abl_q;
        abh_d = abh_q;
        co_d  = co_q;
        if (state_q == StFixup) begin
            // Carry-out of the high half is dropped on purpose: the page wraps.
            abh_d = abh_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (accept) begin
            abl_d = sum[WIDTH-1:0];
            co_d  = sum[WIDTH];
`ifdef ADDR_UNIT_FAST_CARRY_EN
            abh_d = hi_src + {{(WIDTH-1){1'b0}}, cp & sum[WIDTH]};
`else
            abh_d = hi_src;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abl_q <= '0;
            abh_q <= '0;
            co_q  <= 1'b0;
        end else begin
            abl_q <= abl_d;
            abh_q <= abh_d;
            co_q  <= co_d;
        end
    end

    assign AB = {abh_q, abl_q};
    assign co = co_q;

endmodule

// File: tb/tb_addr_unit.sv
// Self-checking bench for addr_unit: directed vector table plus randomized model comparison.
module tb_addr_unit;

    localparam int W = 8;
`ifdef ADDR_UNIT_FAST_CARRY_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, op_valid, op_ready, cp, ci, co;
    logic [3:0]  op;
    logic [1:0]  hop;
    logic [15:0] PC, DB, AH, AB;
    logic [7:0]  REG;

    int total = 0;
    int bad   = 0;

    // Reference model state: address, carry flag, and whether a high-page increment is owed.
    int m_ab, m_co, m_pend;

    always #5 clk = ~clk;

    addr_unit #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .hop      (hop),
        .cp       (cp),
        .ci       (ci),
        .PC       (PC),
        .DB       (DB),
        .AH       (AH),
        .REG      (REG),
        .AB       (AB),
        .co       (co)
    );

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [3:0]  op;
        logic [1:0]  hop;
        logic        cp;
        logic        ci;
        logic [15:0] pc;
        logic [15:0] db;
        logic [7:0]  rg;
        logic [15:0] ab;
        logic        co;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] o,
                                input logic [1:0] h, input logic c, input logic i,
                                input logic [15:0] p, input logic [15:0] d, input logic [7:0] g,
                                input logic [15:0] eab, input logic eco, input logic erdy);
        vec_t t;
        t.rst_n = r; t.valid = v; t.op = o; t.hop = h; t.cp = c; t.ci = i;
        t.pc = p; t.db = d; t.rg = g; t.ab = eab; t.co = eco; t.rdy = erdy;
        return t;
    endfunction

    // Next model state from the current inputs, written from the address arithmetic rules.
    task automatic model_step();
        int base, s, hi, src;
        if (!rst_n) begin
            m_ab = 0; m_co = 0; m_pend = 0;
        end else if (m_pend != 0) begin
            m_ab   = (((m_ab / 256) + 1) % 256) * 256 + (m_ab % 256);
            m_pend = 0;
        end else if (op_valid) begin
            case (int'(op[3:2]))
                0: base = 0;
                1: base = int'(DB) % 256;
                2: base = int'(AH) % 256;
                default: base = int'(PC) % 256;
            endcase
            case (int'(op[1:0]))
                0: s = base + int'(ci);
                1: s = m_ab % 256;
                2: s = base + (m_ab % 256) + int'(ci);
                default: s = base + int'(REG) + int'(ci);
            endcase
            case (int'(hop))
                0: src = m_ab;
                1: src = int'(DB);
                2: src = int'(AH);
                default: src = int'(PC);
            endcase
            hi = src / 256;
            if (cp && s >= 256) begin
                if (Fast) hi = (hi + 1) % 256;
                else m_pend = 1;
            end
            m_ab = hi * 256 + (s % 256);
            m_co = s / 256;
        end
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op = '0; hop = '0; cp = 1'b0; ci = 1'b0;
        PC = '0; DB = '0; AH = 16'h5A3C; REG = '0;

        vecs.push_back(mk(0, 0, 4'h0, 2'd0, 0, 0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 0, 1));
        vecs.push_back(mk(1, 1, 4'hF, 2'd3, 1, 0, 16'h1220, 16'h0000, 8'h10, 16'h1230, 0, 1));
        if (!Fast) begin
            vecs.push_back(mk(1, 1, 4'h7, 2'd1, 1, 0, 16'h1220, 16'h12F0, 8'h20, 16'h1210, 1, 0));
            // Different op offered during the fixup cycle must be stalled.
            vecs.push_back(mk(1, 1, 4'hF, 2'd3, 0, 0, 16'h1220, 16'h12F0, 8'h10, 16'h1310, 1, 1));
            vecs.push_back(mk(1, 1, 4'hF, 2'd3, 0, 0, 16'h1220, 16'h12F0, 8'h10, 16'h1230, 0, 1));
            vecs.push_back(mk(1, 0, 4'h0, 2'd0, 0, 0, 16'h0000, 16'h0000, 8'h00, 16'h1230, 0, 1));
            vecs.push_back(mk(1, 1, 4'h4, 2'd1, 1, 1, 16'h0000, 16'hFFFF, 8'h00, 16'hFF00, 1, 0));
            vecs.push_back(mk(1, 0, 4'h0, 2'd0, 0, 0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1, 1));
            vecs.push_back(mk(1, 1, 4'h7, 2'd1, 1, 0, 16'h0000, 16'h12F0, 8'h20, 16'h1210, 1, 0));
        end else begin
            vecs.push_back(mk(1, 1, 4'h7, 2'd1, 1, 0, 16'h1220, 16'h12F0, 8'h20, 16'h1310, 1, 1));
            vecs.push_back(mk(1, 1, 4'hF, 2'd3, 0, 0, 16'h1220, 16'h12F0, 8'h10, 16'h1230, 0, 1));
            vecs.push_back(mk(1, 0, 4'h0, 2'd0, 0, 0, 16'h0000, 16'h0000, 8'h00, 16'h1230, 0, 1));
            vecs.push_back(mk(1, 1, 4'h4, 2'd1, 1, 1, 16'h0000, 16'hFFFF, 8'h00, 16'h0000, 1, 1));
            vecs.push_back(mk(1, 1, 4'h7, 2'd1, 1, 0, 16'h0000, 16'h12F0, 8'h20, 16'h1310, 1, 1));
        end
        // Reset asserted with an op offered (and, in the default build, a fixup pending).
        vecs.push_back(mk(0, 1, 4'hF, 2'd3, 1, 1, 16'hABCD, 16'h12F0, 8'hFF, 16'h0000, 0, 1));
        vecs.push_back(mk(1, 0, 4'h0, 2'd0, 0, 0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; op_valid = vecs[i].valid; op = vecs[i].op;
            hop = vecs[i].hop; cp = vecs[i].cp; ci = vecs[i].ci;
            PC = vecs[i].pc; DB = vecs[i].db; REG = vecs[i].rg;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d AB", i), 32'(AB), 32'(vecs[i].ab));
            check($sformatf("vec%0d co", i), 32'(co), 32'(vecs[i].co));
            check($sformatf("vec%0d op_ready", i), 32'(op_ready), 32'(vecs[i].rdy));
        end

        rst_n = 1'b0; op_valid = 1'b0;
        model_step();
        @(posedge clk);
        #1;
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            op_valid = ($urandom_range(0, 3) != 0);
            op       = 4'($urandom);
            hop      = 2'($urandom);
            cp       = 1'($urandom);
            ci       = 1'($urandom);
            PC       = 16'($urandom);
            DB       = 16'($urandom);
            AH       = 16'($urandom);
            REG      = 8'($urandom);
            check($sformatf("rnd%0d op_ready", n), 32'(op_ready), 32'(m_pend == 0));
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d AB", n), 32'(AB), 32'(m_ab));
            check($sformatf("rnd%0d co", n), 32'(co), 32'(m_co));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
